// File: rtl/ara_pkg.sv
// Shared cluster-level types and constants for the vector unit.
// Provides the cluster count and the per-cluster mask type.
package ara_pkg;

  localparam int unsigned NrClusters = 4;

  typedef logic [NrClusters-1:0] cluster_mask_t;

endpackage

// File: rtl/vlsu_idx_sync_cnt.sv
// Single-cluster saturating up/down counter of unmatched completions.
// Ports: clk_i, rst_i (async high), clear_i, inc_i, dec_i,
//        cnt_o (registered count), overflow_o (sticky saturation flag).
module vlsu_idx_sync_cnt #(
  parameter int unsigned MaxOutstanding = 3,
  parameter int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                inc_i,
  input  logic                dec_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                overflow_o
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);

  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic                ovf_d, ovf_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end else if (dec_i && !inc_i) begin
      // dec without inc only happens with cnt_q != 0; guard anyway
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/vlsu_idx_sync.sv
// Cross-cluster barrier for indexed ops: fires one sync pulse to all
// VLSUs once every active cluster has an unmatched completion.
// Ports: clk_i, rst_i, idx_completed_i, cluster_active_i, clear_i,
//        idx_completed_sync_o, pending_cnt_o, overflow_o.
module vlsu_idx_sync #(
  parameter int unsigned NrClusters = ara_pkg::NrClusters,
  parameter int unsigned MaxOutstanding = 3,
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrClusters-1:0]          idx_completed_i,
  input  logic [NrClusters-1:0]          cluster_active_i,
  input  logic                           clear_i,
  output logic [NrClusters-1:0]          idx_completed_sync_o,
  output logic [NrClusters*CntWidth-1:0] pending_cnt_o,
  output logic                           overflow_o
);

  logic [NrClusters-1:0] inc;
  logic [NrClusters-1:0] dec;
  logic [NrClusters-1:0] avail;
  logic [NrClusters-1:0] ovf;
  logic                  fire;
  logic [CntWidth-1:0]   cnt [NrClusters];

  logic [NrClusters-1:0] sync_d, sync_q;

  assign inc = idx_completed_i & cluster_active_i;

  // inactive clusters count as available so they never block
  assign fire = (|cluster_active_i) &
                (&(avail | ~cluster_active_i));

  assign dec = {NrClusters{fire}} & cluster_active_i;

  for (genvar c = 0; c < NrClusters; c++) begin : g_cl
    assign avail[c] = (cnt[c] != '0) | inc[c];

    vlsu_idx_sync_cnt #(
      .MaxOutstanding (MaxOutstanding),
      .CntWidth       (CntWidth)
    ) i_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (clear_i),
      .inc_i      (inc[c]),
      .dec_i      (dec[c]),
      .cnt_o      (cnt[c]),
      .overflow_o (ovf[c])
    );

    assign pending_cnt_o[c*CntWidth +: CntWidth] = cnt[c];
  end

  always_comb begin
    sync_d = {NrClusters{fire}};
    if (clear_i) begin
      sync_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign idx_completed_sync_o = sync_q;
  assign overflow_o           = |ovf;

endmodule

// File: tb/tb_vlsu_idx_sync.sv
// Self-checking bench for vlsu_idx_sync: vector table, corner
// sequences and a randomized run against a counting model.
module tb_vlsu_idx_sync;
  import ara_pkg::*;

  localparam int NC  = 4;
  localparam int MAX = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  cluster_mask_t comp = '0;
  cluster_mask_t act = '0;
  logic          clr = 1'b0;
  cluster_mask_t sync;
  logic [7:0]    pend;
  logic          ovf;

  int total = 0;
  int bad = 0;

  vlsu_idx_sync #(
    .NrClusters     (NC),
    .MaxOutstanding (MAX)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .idx_completed_i      (comp),
    .cluster_active_i     (act),
    .clear_i              (clr),
    .idx_completed_sync_o (sync),
    .pending_cnt_o        (pend),
    .overflow_o           (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] comp;
    logic [3:0] act;
    logic       clr;
    logic       sync;
    logic [7:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(logic [3:0] c, logic [3:0] a,
                              logic cl, logic s,
                              logic [7:0] n, logic o);
    vec_t v;
    v.comp = c; v.act = a; v.clr = cl;
    v.sync = s; v.cnt = n; v.ovf = o;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got,
                     logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step(logic [3:0] c, logic [3:0] a, logic cl);
    comp = c; act = a; clr = cl;
    @(posedge clk);
    #1;
  endtask

  int m_cnt[NC];
  bit m_ovf;
  bit m_sync;

  task automatic model(logic [3:0] c, logic [3:0] a, logic cl);
    bit f;
    if (cl) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ovf = 0;
      m_sync = 0;
      return;
    end
    f = (a != 0);
    for (int i = 0; i < NC; i++)
      if (a[i] && m_cnt[i] == 0 && !c[i]) f = 0;
    for (int i = 0; i < NC; i++) begin
      if (a[i]) begin
        m_cnt[i] = m_cnt[i] + int'(c[i]) - int'(f);
        if (m_cnt[i] > MAX) begin
          m_cnt[i] = MAX;
          m_ovf = 1;
        end
      end
    end
    m_sync = f;
  endtask

  function automatic logic [7:0] m_pack();
    logic [7:0] p;
    for (int i = 0; i < NC; i++) p[i*2 +: 2] = 2'(m_cnt[i]);
    return p;
  endfunction

  initial begin
    int pulses;
    vecs[0]  = mk(4'b0001, 4'hF, 0, 0, 8'b00000001, 0);
    vecs[1]  = mk(4'b0000, 4'hF, 0, 0, 8'b00000001, 0);
    vecs[2]  = mk(4'b0010, 4'hF, 0, 0, 8'b00000101, 0);
    vecs[3]  = mk(4'b0100, 4'hF, 0, 0, 8'b00010101, 0);
    vecs[4]  = mk(4'b1000, 4'hF, 0, 1, 8'b00000000, 0);
    vecs[5]  = mk(4'b0000, 4'hF, 0, 0, 8'b00000000, 0);
    vecs[6]  = mk(4'b1111, 4'hF, 0, 1, 8'b00000000, 0);
    vecs[7]  = mk(4'b1111, 4'hF, 0, 1, 8'b00000000, 0);
    vecs[8]  = mk(4'b0001, 4'hF, 0, 0, 8'b00000001, 0);
    vecs[9]  = mk(4'b0001, 4'hF, 0, 0, 8'b00000010, 0);
    vecs[10] = mk(4'b0001, 4'hF, 0, 0, 8'b00000011, 0);
    vecs[11] = mk(4'b0001, 4'hF, 0, 0, 8'b00000011, 1);
    vecs[12] = mk(4'b0000, 4'hF, 0, 0, 8'b00000011, 1);
    vecs[13] = mk(4'b1110, 4'hF, 0, 1, 8'b00000010, 1);
    vecs[14] = mk(4'b1111, 4'hF, 1, 0, 8'b00000000, 0);
    vecs[15] = mk(4'b1000, 4'h3, 0, 0, 8'b00000000, 0);
    vecs[16] = mk(4'b0011, 4'h3, 0, 1, 8'b00000000, 0);
    vecs[17] = mk(4'b1111, 4'h0, 0, 0, 8'b00000000, 0);
    vecs[18] = mk(4'b0001, 4'h3, 0, 0, 8'b00000001, 0);
    vecs[19] = mk(4'b0000, 4'h1, 0, 1, 8'b00000000, 0);
    vecs[20] = mk(4'b0100, 4'hF, 0, 0, 8'b00010000, 0);
    vecs[21] = mk(4'b1011, 4'hB, 0, 1, 8'b00010000, 0);
    vecs[22] = mk(4'b0000, 4'hF, 0, 0, 8'b00010000, 0);
    vecs[23] = mk(4'b0000, 4'hF, 1, 0, 8'b00000000, 0);

    #1;
    chk("rst_sync", 32'(sync), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].comp, vecs[i].act, vecs[i].clr);
      chk($sformatf("vec%0d_sync", i), 32'(sync),
          32'({4{vecs[i].sync}}));
      chk($sformatf("vec%0d_pend", i), 32'(pend),
          32'(vecs[i].cnt));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf),
          32'(vecs[i].ovf));
    end

    // async reset mid-stream with cluster 2 holding 2
    step(4'b0100, 4'hF, 0);
    step(4'b0100, 4'hF, 0);
    chk("pre_rst_pend", 32'(pend), 32'h20);
    comp = '0;
    #3 rst = 1'b1;
    #1;
    chk("async_rst_pend", 32'(pend), 0);
    chk("async_rst_sync", 32'(sync), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'hF, 0);
      if (sync != 0) pulses++;
    end
    step(4'b1111, 4'hF, 0);
    if (sync != 0) pulses++;
    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 4'hF, 0);
      if (sync != 0) pulses++;
    end
    chk("post_rst_pulses", 32'(pulses), 1);
    chk("post_rst_pend", 32'(pend), 0);

    // randomized run against the counting model
    step(4'b0000, 4'hF, 1);
    foreach (m_cnt[i]) m_cnt[i] = 0;
    m_ovf = 0;
    m_sync = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] rc, ra;
      logic       rl;
      rc = 4'($urandom);
      ra = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      rl = ($urandom_range(0, 99) == 0);
      model(rc, ra, rl);
      step(rc, ra, rl);
      chk($sformatf("rnd%0d_sync", n), 32'(sync),
          32'({4{m_sync}}));
      chk($sformatf("rnd%0d_pend", n), 32'(pend),
          32'(m_pack()));
      chk($sformatf("rnd%0d_ovf", n), 32'(ovf), 32'(m_ovf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vlsu_idx_sync.md
Name: vlsu_idx_sync

Overview:
- Cross-cluster barrier for indexed vector memory operations. Sits between the VLSUs of all clusters.
- Each cluster's VLSU emits a registered idx_completed pulse when its address generator finishes its share of one indexed op. This block counts completions per cluster.
- Once every active cluster has at least one unmatched completion, it broadcasts one registered sync pulse back to every VLSU (idx_completed_sync input). The pulse releases the next indexed op in lockstep.

Parameters:
- NrClusters, 4, number of clusters/VLSUs participating; must be >= 1.
- MaxOutstanding, 3, max unmatched completions a single cluster may run ahead; must be >= 1.
- CntWidth, $clog2(MaxOutstanding+1), derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- idx_completed_i  in  NrClusters  per-cluster completion pulse, 1 cycle per completed indexed op.
- cluster_active_i  in  NrClusters  participation mask; inactive clusters are excluded from the barrier.
- clear_i  in  1  synchronous flush of all counters and error state.
- idx_completed_sync_o  out  NrClusters  registered sync pulse, identical bit per cluster.
- pending_cnt_o  out  NrClusters*CntWidth  current per-cluster unmatched count (debug/perf).
- overflow_o  out  1  sticky error: a cluster exceeded MaxOutstanding.

Behaviour:
- Reset (rst_i high, async): all counters 0, idx_completed_sync_o=0, overflow_o=0, pending_cnt_o=0.
- Per cluster c, each cycle:
  - inc_c = idx_completed_i[c] & cluster_active_i[c].
  - avail_c = (cnt_c != 0) | inc_c.
- fire = (|cluster_active_i) & AND over c of (avail_c | ~cluster_active_i[c]).
- Next count:
  - cnt_c_next = cnt_c + inc_c - (fire & cluster_active_i[c]).
  - Increment and decrement in the same cycle leave the count unchanged.
  - A completion arriving in the firing cycle is consumed directly, so fire with all counts 0 is legal.
- idx_completed_sync_o <= {NrClusters{fire}}. Latency is 1 cycle from the last required completion pulse to the sync pulse. The pulse is exactly 1 cycle wide per fire.
- Back-to-back fires are allowed on consecutive cycles if counts permit. There is no handshake; consumers must accept every pulse.
- Overflow: if cnt_c == MaxOutstanding and inc_c and no fire, the count saturates (holds MaxOutstanding) and overflow_o <= 1. overflow_o is sticky until rst_i or clear_i.
- Inactive cluster: its idx_completed_i is ignored and its counter holds its value. It neither blocks nor is decremented by fire.
  - Deasserting cluster_active_i does not clear the counter. Software issues clear_i on reconfiguration.
- All clusters inactive: fire=0, sync stays 0.
- clear_i (sync): all counters 0, overflow_o 0, idx_completed_sync_o 0 next cycle. clear_i has priority over inc/fire in the same cycle; that cycle's pulses are dropped.
- rst_i asserted mid-operation: immediate return to reset values. Pending completions are lost, and no sync pulse is produced after deassertion until new completions arrive.
- pending_cnt_o is the registered cnt_c; cluster c occupies bits [c*CntWidth +: CntWidth].

Decomposition:
- ara_pkg: cluster_mask_t (logic [NrClusters-1:0]) and the NrClusters constant, shared with the cluster top and VLSU wiring.
- Sub-module vlsu_idx_sync_cnt: a single-cluster saturating up/down counter with inc, dec, clear and overflow flag, instantiated NrClusters times.
- The top holds the fire reduction and the output registers.

Test Plan:
- Reset, all active, one completion pulse per cluster in cycles 2,4,6,8 -> sync 0 until cycle 9, then all 4 bits high for exactly 1 cycle; all counts return to 0.
- All 4 clusters pulse in the same cycle 5 with counts 0 -> sync pulse in cycle 6, counts remain 0.
- Cluster 0 pulses 3 times, then clusters 1-3 pulse together three times -> 3 sync pulses, one per round; cnt0 goes 3,2,1,0.
- Cluster 0 pulses 4 times with MaxOutstanding=3 and no other activity -> cnt0 saturates at 3, overflow_o=1 after the 4th pulse and stays 1; clear_i -> cnt0=0, overflow_o=0.
- cluster_active_i=4'b0011, clusters 0 and 1 pulse once, cluster 3 pulses -> exactly one sync pulse, cnt3 unchanged at 0; mask=0 with pulses -> no sync.
- Cluster 2 holds 2 pending, rst_i asserted for 1 cycle mid-stream -> all counts 0 immediately; later single-round completions produce exactly one sync.
